// File: rtl/rename_map_table.sv
// Checkpointed register rename map: speculative and architectural maps, per-preg ready table
// and a FIFO of branch snapshots. Optional same-cycle writeback bypass: RMT_WB_BYPASS_EN.
module rename_map_table #(
   parameter int DECODE_WIDTH = 2,
   parameter int WB_WIDTH     = 4,
   parameter int PHY_REG_NUM  = 64,
   parameter int CKPT_NUM     = 4,
   localparam int PW = $clog2(PHY_REG_NUM),
   localparam int CW = $clog2(CKPT_NUM)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DECODE_WIDTH-1:0]          rename_valid_i,
   output logic                             rename_ready_o,
   input  logic [DECODE_WIDTH-1:0][4:0]     src0_i,
   input  logic [DECODE_WIDTH-1:0][4:0]     src1_i,
   input  logic [DECODE_WIDTH-1:0][4:0]     dest_i,
   input  logic [DECODE_WIDTH-1:0]          dest_valid_i,
   input  logic [DECODE_WIDTH-1:0][PW-1:0]  preg_i,
   input  logic [DECODE_WIDTH-1:0]          br_i,
   output logic [DECODE_WIDTH-1:0][PW-1:0]  psrc0_o,
   output logic [DECODE_WIDTH-1:0][PW-1:0]  psrc1_o,
   output logic [DECODE_WIDTH-1:0][PW-1:0]  ppdst_o,
   output logic [DECODE_WIDTH-1:0]          psrc0_ready_o,
   output logic [DECODE_WIDTH-1:0]          psrc1_ready_o,
   output logic [CW-1:0]                    ckpt_id_o,
   input  logic [WB_WIDTH-1:0]              wb_i,
   input  logic [WB_WIDTH-1:0][PW-1:0]      wb_pdest_i,
   input  logic [DECODE_WIDTH-1:0]          commit_i,
   input  logic [DECODE_WIDTH-1:0][4:0]     commit_dest_i,
   input  logic [DECODE_WIDTH-1:0][PW-1:0]  commit_preg_i,
   input  logic                             br_resolve_i,
   input  logic                             redirect_i,
   input  logic [CW-1:0]                    redirect_id_i,
   input  logic                             flush_i,
   output logic                             ckpt_full_o
);

   typedef logic [31:0][PW-1:0] map_t;

   map_t                   spec_map_q, arch_map_q, map_upd, snap;
   map_t                   ckpt_q [CKPT_NUM];
   logic [PHY_REG_NUM-1:0] ready_q, ready_next;
   logic [CW-1:0]          head_q, tail_q, head_n;
   logic [CW:0]            count_q, count_n;
   logic [DECODE_WIDTH-1:0] dv;
   logic                   fire, push, resolve_ok;

   assign ckpt_full_o    = (count_q == (CW+1)'(CKPT_NUM));
   assign ckpt_id_o      = tail_q;
   assign rename_ready_o = !flush_i && !redirect_i && !((|br_i) && ckpt_full_o);
   assign fire           = (|rename_valid_i) && rename_ready_o;
   assign push           = fire && (|br_i);
   assign resolve_ok     = br_resolve_i && (count_q != '0);
   assign head_n         = head_q + CW'(resolve_ok);
   assign count_n        = count_q + (CW+1)'(push) - (CW+1)'(resolve_ok);

   always_comb begin : dest_write
      dv = '0;
      for (int i = 0; i < DECODE_WIDTH; i++)
         dv[i] = rename_valid_i[i] && dest_valid_i[i] && (dest_i[i] != 5'd0);
   end

   // Per-slot lookup: spec map first, then any older slot in the group writing the same reg wins.
   always_comb begin : lookup
      logic [4:0]    a;
      logic [PW-1:0] p;
      logic          r;
      a = '0;
      p = '0;
      r = 1'b0;
      psrc0_o = '0;
      psrc1_o = '0;
      ppdst_o = '0;
      psrc0_ready_o = '0;
      psrc1_ready_o = '0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         for (int k = 0; k < 3; k++) begin
            a = (k == 0) ? src0_i[i] : (k == 1) ? src1_i[i] : dest_i[i];
            p = spec_map_q[a];
            r = ready_q[p];
`ifdef RMT_WB_BYPASS_EN
            for (int w = 0; w < WB_WIDTH; w++)
               if (wb_i[w] && (wb_pdest_i[w] == p)) r = 1'b1;
`else
`endif
            for (int j = 0; j < i; j++) begin
               if (dv[j] && (dest_i[j] == a)) begin
                  p = preg_i[j];
                  r = 1'b0;
               end
            end
            if (a == 5'd0) begin
               p = '0;
               r = 1'b1;
            end
            case (k)
               0:       begin psrc0_o[i] = p; psrc0_ready_o[i] = r; end
               1:       begin psrc1_o[i] = p; psrc1_ready_o[i] = r; end
               default: ppdst_o[i] = p;
            endcase
         end
      end
   end

   // NOTE: blocking assignments here are deliberate: each slot must see the map left by older slots.
   always_comb begin : map_walk
      map_upd = spec_map_q;
      snap    = spec_map_q;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         if (dv[i]) map_upd[dest_i[i]] = preg_i[i];
         if (br_i[i]) snap = map_upd;
      end
   end

   always_comb begin : ready_walk
      ready_next = ready_q;
      for (int w = 0; w < WB_WIDTH; w++)
         if (wb_i[w]) ready_next[wb_pdest_i[w]] = 1'b1;
      if (fire) begin
         for (int i = 0; i < DECODE_WIDTH; i++)
            if (dv[i]) ready_next[preg_i[i]] = 1'b0;
      end
      ready_next[0] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < 32; a++) begin
            spec_map_q[a] <= PW'(a);
            arch_map_q[a] <= PW'(a);
         end
         ready_q <= '1;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DECODE_WIDTH; i++)
            if (commit_i[i] && (commit_dest_i[i] != 5'd0))
               arch_map_q[commit_dest_i[i]] <= commit_preg_i[i];
         if (flush_i) begin
            spec_map_q <= arch_map_q;
            ready_q    <= '1;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
         end else begin
            ready_q <= ready_next;
            head_q  <= head_n;
            if (redirect_i) begin
               spec_map_q <= ckpt_q[redirect_id_i];
               tail_q     <= redirect_id_i;
               count_q    <= {1'b0, redirect_id_i - head_n};
            end else begin
               if (fire) spec_map_q <= map_upd;
               if (push) tail_q <= tail_q + 1'b1;
               count_q <= count_n;
            end
         end
      end
   end

   // NOTE: snapshot storage is not reset; only head/tail/count define which entries are live.
   always_ff @(posedge clk) begin
      if (push) ckpt_q[tail_q] <= snap;
   end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed self-checking bench for rename_map_table; expected values are hand-derived.
module tb_rename_map_table;

   localparam int DW = 2;
   localparam int WW = 4;
   localparam int PW = 6;
   localparam int CW = 2;
`ifdef RMT_WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [DW-1:0]          rename_valid_i;
   logic                   rename_ready_o;
   logic [DW-1:0][4:0]     src0_i, src1_i, dest_i;
   logic [DW-1:0]          dest_valid_i;
   logic [DW-1:0][PW-1:0]  preg_i;
   logic [DW-1:0]          br_i;
   logic [DW-1:0][PW-1:0]  psrc0_o, psrc1_o, ppdst_o;
   logic [DW-1:0]          psrc0_ready_o, psrc1_ready_o;
   logic [CW-1:0]          ckpt_id_o;
   logic [WW-1:0]          wb_i;
   logic [WW-1:0][PW-1:0]  wb_pdest_i;
   logic [DW-1:0]          commit_i;
   logic [DW-1:0][4:0]     commit_dest_i;
   logic [DW-1:0][PW-1:0]  commit_preg_i;
   logic                   br_resolve_i, redirect_i, flush_i;
   logic [CW-1:0]          redirect_id_i;
   logic                   ckpt_full_o;

   int checks = 0;
   int failures = 0;

   rename_map_table dut (
      .clk(clk), .rst(rst),
      .rename_valid_i(rename_valid_i), .rename_ready_o(rename_ready_o),
      .src0_i(src0_i), .src1_i(src1_i), .dest_i(dest_i),
      .dest_valid_i(dest_valid_i), .preg_i(preg_i), .br_i(br_i),
      .psrc0_o(psrc0_o), .psrc1_o(psrc1_o), .ppdst_o(ppdst_o),
      .psrc0_ready_o(psrc0_ready_o), .psrc1_ready_o(psrc1_ready_o),
      .ckpt_id_o(ckpt_id_o),
      .wb_i(wb_i), .wb_pdest_i(wb_pdest_i),
      .commit_i(commit_i), .commit_dest_i(commit_dest_i), .commit_preg_i(commit_preg_i),
      .br_resolve_i(br_resolve_i), .redirect_i(redirect_i), .redirect_id_i(redirect_id_i),
      .flush_i(flush_i), .ckpt_full_o(ckpt_full_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      rename_valid_i = '0; src0_i = '0; src1_i = '0; dest_i = '0; dest_valid_i = '0;
      preg_i = '0; br_i = '0; wb_i = '0; wb_pdest_i = '0; commit_i = '0;
      commit_dest_i = '0; commit_preg_i = '0; br_resolve_i = 1'b0;
      redirect_i = 1'b0; redirect_id_i = '0; flush_i = 1'b0;
   endtask

   task automatic slot(input int s, input logic v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] d, input logic dvl, input logic [PW-1:0] p, input logic b);
      rename_valid_i[s] = v; src0_i[s] = a0; src1_i[s] = a1;
      dest_i[s] = d; dest_valid_i[s] = dvl; preg_i[s] = p; br_i[s] = b;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      idle();
      slot(0, 1'b0, 5'd9, 5'd0, 5'd17, 1'b0, 6'd0, 1'b0);
      #1;
      checks++; if (rename_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0d exp=1", rename_ready_o); end
      checks++; if (ckpt_full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%0d exp=0", ckpt_full_o); end
      checks++; if (ckpt_id_o !== 2'd0) begin failures++; $display("FAIL reset_ckpt_id got=%0d exp=0", ckpt_id_o); end
      checks++; if (psrc0_o[0] !== 6'd9 || psrc0_ready_o[0] !== 1'b1) begin failures++; $display("FAIL reset_map9 got=%0d/%0d exp=9/1", psrc0_o[0], psrc0_ready_o[0]); end
      checks++; if (psrc1_o[0] !== 6'd0 || psrc1_ready_o[0] !== 1'b1) begin failures++; $display("FAIL reset_map0 got=%0d/%0d exp=0/1", psrc1_o[0], psrc1_ready_o[0]); end
      checks++; if (ppdst_o[0] !== 6'd17) begin failures++; $display("FAIL reset_map17 got=%0d exp=17", ppdst_o[0]); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      do_reset();
      idle();
      slot(0, 1'b1, 5'd5, 5'd7, 5'd5, 1'b1, 6'd40, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd5 || psrc0_ready_o[0] !== 1'b1) begin failures++; $display("FAIL basic_psrc0 got=%0d/%0d exp=5/1", psrc0_o[0], psrc0_ready_o[0]); end
      checks++; if (psrc1_o[0] !== 6'd7) begin failures++; $display("FAIL basic_psrc1 got=%0d exp=7", psrc1_o[0]); end
      checks++; if (ppdst_o[0] !== 6'd5) begin failures++; $display("FAIL basic_ppdst got=%0d exp=5", ppdst_o[0]); end
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd40 || psrc0_ready_o[0] !== 1'b0) begin failures++; $display("FAIL basic_next got=%0d/%0d exp=40/0", psrc0_o[0], psrc0_ready_o[0]); end
      @(negedge clk);
   endtask

   task automatic test_intra_group();
      do_reset();
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 6'd41, 1'b0);
      slot(1, 1'b1, 5'd3, 5'd4, 5'd3, 1'b1, 6'd42, 1'b0);
      #1;
      checks++; if (psrc0_o[1] !== 6'd41 || psrc0_ready_o[1] !== 1'b0) begin failures++; $display("FAIL intra_psrc0 got=%0d/%0d exp=41/0", psrc0_o[1], psrc0_ready_o[1]); end
      checks++; if (ppdst_o[1] !== 6'd41) begin failures++; $display("FAIL intra_ppdst1 got=%0d exp=41", ppdst_o[1]); end
      checks++; if (ppdst_o[0] !== 6'd3) begin failures++; $display("FAIL intra_ppdst0 got=%0d exp=3", ppdst_o[0]); end
      checks++; if (psrc1_o[1] !== 6'd4 || psrc1_ready_o[1] !== 1'b1) begin failures++; $display("FAIL intra_psrc1 got=%0d/%0d exp=4/1", psrc1_o[1], psrc1_ready_o[1]); end
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd42 || psrc0_ready_o[0] !== 1'b0) begin failures++; $display("FAIL intra_next got=%0d/%0d exp=42/0", psrc0_o[0], psrc0_ready_o[0]); end
      @(negedge clk);
   endtask

   task automatic test_ckpt_full();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         idle();
         slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
         #1;
         checks++; if (ckpt_id_o !== 2'(k) || rename_ready_o !== 1'b1) begin failures++; $display("FAIL fill_id got=%0d/%0d exp=%0d/1", ckpt_id_o, rename_ready_o, k); end
         @(negedge clk);
      end
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
      #1;
      checks++; if (ckpt_full_o !== 1'b1 || rename_ready_o !== 1'b0) begin failures++; $display("FAIL full_stall got=%0d/%0d exp=1/0", ckpt_full_o, rename_ready_o); end
      br_resolve_i = 1'b1;
      #1;
      checks++; if (rename_ready_o !== 1'b0) begin failures++; $display("FAIL full_no_credit got=%0d exp=0", rename_ready_o); end
      @(negedge clk);
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
      #1;
      checks++; if (ckpt_full_o !== 1'b0 || rename_ready_o !== 1'b1 || ckpt_id_o !== 2'd0) begin failures++; $display("FAIL full_after_resolve got=%0d/%0d/%0d exp=0/1/0", ckpt_full_o, rename_ready_o, ckpt_id_o); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (ckpt_full_o !== 1'b1) begin failures++; $display("FAIL full_again got=%0d exp=1", ckpt_full_o); end
      @(negedge clk);
   endtask

   task automatic test_redirect();
      do_reset();
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
      @(negedge clk);
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 6'd41, 1'b1);
      slot(1, 1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 6'd45, 1'b0);
      #1;
      checks++; if (ckpt_id_o !== 2'd1) begin failures++; $display("FAIL redir_ckpt_id got=%0d exp=1", ckpt_id_o); end
      @(negedge clk);
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 6'd50, 1'b0);
      #1;
      checks++; if (ppdst_o[0] !== 6'd41) begin failures++; $display("FAIL redir_ppdst got=%0d exp=41", ppdst_o[0]); end
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
      redirect_i = 1'b1; redirect_id_i = 2'd1;
      #1;
      checks++; if (rename_ready_o !== 1'b0 || psrc0_o[0] !== 6'd50) begin failures++; $display("FAIL redir_during got=%0d/%0d exp=0/50", rename_ready_o, psrc0_o[0]); end
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 6'd0, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd41 || psrc0_ready_o[0] !== 1'b0) begin failures++; $display("FAIL redir_r3 got=%0d/%0d exp=41/0", psrc0_o[0], psrc0_ready_o[0]); end
      checks++; if (psrc1_o[0] !== 6'd4 || psrc1_ready_o[0] !== 1'b1) begin failures++; $display("FAIL redir_r4 got=%0d/%0d exp=4/1", psrc1_o[0], psrc1_ready_o[0]); end
      checks++; if (rename_ready_o !== 1'b1 || ckpt_id_o !== 2'd1 || ckpt_full_o !== 1'b0) begin failures++; $display("FAIL redir_ptrs got=%0d/%0d/%0d exp=1/1/0", rename_ready_o, ckpt_id_o, ckpt_full_o); end
      for (int k = 1; k < 4; k++) begin
         idle();
         slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
         #1;
         checks++; if (ckpt_id_o !== 2'(k) || ckpt_full_o !== 1'b0) begin failures++; $display("FAIL redir_refill got=%0d/%0d exp=%0d/0", ckpt_id_o, ckpt_full_o, k); end
         @(negedge clk);
      end
      idle();
      #1;
      checks++; if (ckpt_full_o !== 1'b1) begin failures++; $display("FAIL redir_count got=%0d exp=1", ckpt_full_o); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      do_reset();
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 6'd41, 1'b0);
      commit_i = 2'b01; commit_dest_i[0] = 5'd3; commit_preg_i[0] = 6'd41;
      @(negedge clk);
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 6'd55, 1'b1);
      commit_i = 2'b11;
      commit_dest_i[0] = 5'd5; commit_preg_i[0] = 6'd60;
      commit_dest_i[1] = 5'd5; commit_preg_i[1] = 6'd61;
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
      flush_i = 1'b1;
      #1;
      checks++; if (rename_ready_o !== 1'b0 || psrc0_o[0] !== 6'd55) begin failures++; $display("FAIL flush_during got=%0d/%0d exp=0/55", rename_ready_o, psrc0_o[0]); end
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd3, 5'd5, 5'd0, 1'b0, 6'd0, 1'b0);
      slot(1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd41 || psrc0_ready_o[0] !== 1'b1) begin failures++; $display("FAIL flush_r3 got=%0d/%0d exp=41/1", psrc0_o[0], psrc0_ready_o[0]); end
      checks++; if (psrc1_o[0] !== 6'd61 || psrc1_ready_o[0] !== 1'b1) begin failures++; $display("FAIL flush_r5 got=%0d/%0d exp=61/1", psrc1_o[0], psrc1_ready_o[0]); end
      checks++; if (psrc0_o[1] !== 6'd7) begin failures++; $display("FAIL flush_r7 got=%0d exp=7", psrc0_o[1]); end
      checks++; if (rename_ready_o !== 1'b1 || ckpt_full_o !== 1'b0) begin failures++; $display("FAIL flush_after got=%0d/%0d exp=1/0", rename_ready_o, ckpt_full_o); end
      for (int k = 0; k < 4; k++) begin
         idle();
         slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0, 1'b1);
         #1;
         checks++; if (ckpt_full_o !== 1'b0) begin failures++; $display("FAIL flush_refill_%0d got=%0d exp=0", k, ckpt_full_o); end
         @(negedge clk);
      end
      idle();
      #1;
      checks++; if (ckpt_full_o !== 1'b1) begin failures++; $display("FAIL flush_empty got=%0d exp=1", ckpt_full_o); end
      @(negedge clk);
   endtask

   task automatic test_writeback();
      do_reset();
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 6'd40, 1'b0);
      @(negedge clk);
      idle();
      slot(0, 1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 6'd44, 1'b0);
      slot(1, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0);
      wb_i = 4'b0110; wb_pdest_i[1] = 6'd44; wb_pdest_i[2] = 6'd40;
      #1;
      checks++; if (psrc0_o[0] !== 6'd40 || psrc0_ready_o[0] !== BYP) begin failures++; $display("FAIL wb_bypass got=%0d/%0d exp=40/%0d", psrc0_o[0], psrc0_ready_o[0], BYP); end
      checks++; if (psrc0_o[1] !== 6'd44 || psrc0_ready_o[1] !== 1'b0) begin failures++; $display("FAIL wb_intra got=%0d/%0d exp=44/0", psrc0_o[1], psrc0_ready_o[1]); end
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd9, 5'd10, 5'd0, 1'b0, 6'd0, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd40 || psrc0_ready_o[0] !== 1'b1) begin failures++; $display("FAIL wb_next got=%0d/%0d exp=40/1", psrc0_o[0], psrc0_ready_o[0]); end
      checks++; if (psrc1_o[0] !== 6'd44 || psrc1_ready_o[0] !== 1'b0) begin failures++; $display("FAIL wb_alloc_wins got=%0d/%0d exp=44/0", psrc1_o[0], psrc1_ready_o[0]); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_reset();
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd1, 1'b1, 6'd20, 1'b0);
      @(negedge clk);
      idle();
      slot(0, 1'b1, 5'd1, 5'd0, 5'd1, 1'b1, 6'd21, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd20 || psrc0_ready_o[0] !== 1'b0 || ppdst_o[0] !== 6'd20) begin failures++; $display("FAIL b2b_chain got=%0d/%0d/%0d exp=20/0/20", psrc0_o[0], psrc0_ready_o[0], ppdst_o[0]); end
      @(negedge clk);
      idle();
      slot(0, 1'b0, 5'd1, 5'd0, 5'd1, 1'b1, 6'd22, 1'b0);
      #1;
      checks++; if (psrc0_o[0] !== 6'd21) begin failures++; $display("FAIL b2b_second got=%0d exp=21", psrc0_o[0]); end
      @(negedge clk);
      idle();
      slot(0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 6'd30, 1'b0);
      slot(1, 1'b1, 5'd0, 5'd1, 5'd0, 1'b0, 6'd0, 1'b0);
      #1;
      checks++; if (psrc1_o[1] !== 6'd21) begin failures++; $display("FAIL b2b_invalid_slot got=%0d exp=21", psrc1_o[1]); end
      checks++; if (psrc0_o[1] !== 6'd0 || psrc0_ready_o[1] !== 1'b1 || ppdst_o[0] !== 6'd0) begin failures++; $display("FAIL b2b_r0 got=%0d/%0d/%0d exp=0/1/0", psrc0_o[1], psrc0_ready_o[1], ppdst_o[0]); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (psrc0_o[0] !== 6'd0 || psrc0_ready_o[0] !== 1'b1) begin failures++; $display("FAIL b2b_r0_kept got=%0d/%0d exp=0/1", psrc0_o[0], psrc0_ready_o[0]); end
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_intra_group();
      test_ckpt_full();
      test_redirect();
      test_flush();
      test_writeback();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
